// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol mapper: mode encodings, Q2.14 level
// constants and the Gray-coded bit-group to constellation-point function.
package qam_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_QAM16 = 2'd2,
        MOD_QAM64 = 2'd3
    } qam_mode_e;

    // Q2.14 magnitudes, 16384 = 1.0, normalised to unit average power per mode
    localparam logic [15:0] LVL_BPSK  = 16'h4000;
    localparam logic [15:0] LVL_QPSK  = 16'h2D41;
    localparam logic [15:0] LVL16_L1  = 16'h143D;
    localparam logic [15:0] LVL16_L3  = 16'h3CB7;
    localparam logic [15:0] LVL64_L1  = 16'h09E0;
    localparam logic [15:0] LVL64_L3  = 16'h1DA0;
    localparam logic [15:0] LVL64_L5  = 16'h3161;
    localparam logic [15:0] LVL64_L7  = 16'h4521;

    typedef struct packed {
        logic [15:0] im;
        logic [15:0] re;
    } qam_point_t;

    function automatic logic [15:0] signed_level(input logic pos, input logic [15:0] mag);
        return pos ? mag : (~mag + 16'd1);
    endfunction

    // Gray code: MSB is the sign (1 = positive), remaining bits pick the magnitude
    function automatic logic [15:0] level_16qam(input logic [1:0] b);
        return signed_level(b[1], b[0] ? LVL16_L1 : LVL16_L3);
    endfunction

    function automatic logic [15:0] level_64qam(input logic [2:0] b);
        logic [15:0] mag;
        case (b[1:0])
            2'b00:   mag = LVL64_L7;
            2'b01:   mag = LVL64_L5;
            2'b11:   mag = LVL64_L3;
            default: mag = LVL64_L1;
        endcase
        return signed_level(b[2], mag);
    endfunction

    function automatic qam_point_t qam_map(input logic [5:0] bits, input qam_mode_e mode);
        qam_point_t p;
        case (mode)
            MOD_BPSK: begin
                p.re = signed_level(~bits[0], LVL_BPSK);
                p.im = 16'h0000;
            end
            MOD_QPSK: begin
                p.re = signed_level(~bits[0], LVL_QPSK);
                p.im = signed_level(~bits[1], LVL_QPSK);
            end
            MOD_QAM16: begin
                p.re = level_16qam(bits[1:0]);
                p.im = level_16qam(bits[3:2]);
            end
            default: begin
                p.re = level_64qam(bits[2:0]);
                p.im = level_64qam(bits[5:3]);
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/qam_out_fifo.sv
// First-word-fall-through output FIFO; the head entry is visible on rd_data
// whenever the FIFO is not empty, and rd_data reads zero when it is.
module qam_out_fifo #(
    parameter int DW2   = 32,
    parameter int DEPTH = 4
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     wr_en,
    input  logic [DW2-1:0]           wr_data,
    input  logic                     rd_en,
    output logic [DW2-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW2-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    // NOTE: storage has no reset; validity is tracked by count, so clearing it would only add reset fan-out.
    always_ff @(posedge CLK_I) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/qam_mapper.sv
// Per-symbol selectable BPSK/QPSK/16QAM/64QAM mapper with a credit-controlled
// input stage and a FWFT output FIFO towards the IFFT buffer.
module qam_mapper
    import qam_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic [5:0]      DAT_I,
    input  logic [1:0]      MOD_I,
    input  logic            CYC_I,
    input  logic            STB_I,
    input  logic            WE_I,
    output logic            ACK_O,
    output logic [2*DW-1:0] DAT_O,
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    input  logic            ACK_I
);

    localparam int AW = $clog2(DEPTH);

    logic            ena;
    logic            s1_valid;
    logic [5:0]      s1_dat;
    qam_mode_e       s1_mod;
    qam_point_t      point;
    logic [DW-1:0]   im_w;
    logic [DW-1:0]   re_w;
    logic [AW:0]     fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW+1:0]   occupancy;

    assign ena = CYC_I & STB_I & WE_I;

    // The symbol in stage 1 already owns a FIFO slot, so it counts against the credit
    assign occupancy = {1'b0, fifo_count} + {{(AW+1){1'b0}}, s1_valid};
    assign ACK_O     = ena & ~fifo_full & (occupancy < (AW+2)'(DEPTH));

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            s1_valid <= 1'b0;
            s1_dat   <= '0;
            s1_mod   <= MOD_BPSK;
        end else begin
            s1_valid <= ACK_O;
            if (ACK_O) begin
                s1_dat <= DAT_I;
                s1_mod <= qam_mode_e'(MOD_I);
            end
        end
    end

    assign point = qam_map(s1_dat, s1_mod);

    generate
        if (DW >= 16) begin : g_extend
            assign im_w = DW'($signed(point.im));
            assign re_w = DW'($signed(point.re));
        end else begin : g_truncate
            assign im_w = point.im[15 -: DW];
            assign re_w = point.re[15 -: DW];
        end
    endgenerate

    qam_out_fifo #(
        .DW2   (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .wr_en   (s1_valid),
        .wr_data ({im_w, re_w}),
        .rd_en   (STB_O & ACK_I),
        .rd_data (DAT_O),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign STB_O = ~fifo_empty;
    assign WE_O  = STB_O;

    // Downstream cycle stays open until every accepted symbol has been handed over
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            CYC_O <= 1'b0;
        end else if (CYC_I) begin
            CYC_O <= 1'b1;
        end else if (~s1_valid & fifo_empty) begin
            CYC_O <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qam_mapper.sv
// Scoreboard bench for qam_mapper: expected points are queued at input
// acceptance and compared at each downstream handshake.
module tb_qam_mapper;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic            CLK_I = 1'b0;
    logic            RST_I;
    logic [5:0]      DAT_I;
    logic [1:0]      MOD_I;
    logic            CYC_I, STB_I, WE_I;
    logic            ACK_O;
    logic [2*DW-1:0] DAT_O;
    logic            CYC_O, STB_O, WE_O;
    logic            ACK_I;

    qam_mapper #(.DW(DW), .DEPTH(DEPTH)) dut (
        .CLK_I (CLK_I), .RST_I (RST_I),
        .DAT_I (DAT_I), .MOD_I (MOD_I),
        .CYC_I (CYC_I), .STB_I (STB_I), .WE_I (WE_I), .ACK_O (ACK_O),
        .DAT_O (DAT_O), .CYC_O (CYC_O), .STB_O (STB_O), .WE_O (WE_O),
        .ACK_I (ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic        ack;
        logic        stb;
        logic        we;
        logic        cyc;
        logic        hs;
        logic        sb_empty;
        logic [31:0] dat;
        logic [31:0] exp;
    } obs_t;

    logic [31:0] sb[$];
    int checks   = 0;
    int failures = 0;

    // Independent reference: explicit lookup tables of the signed Q2.14 levels
    function automatic logic [15:0] ref16(input logic [1:0] b);
        case (b)
            2'b00:   return 16'hC349;
            2'b01:   return 16'hEBC3;
            2'b10:   return 16'h3CB7;
            default: return 16'h143D;
        endcase
    endfunction

    function automatic logic [15:0] ref64(input logic [2:0] b);
        case (b)
            3'b000:  return 16'hBADF;
            3'b001:  return 16'hCE9F;
            3'b010:  return 16'hF620;
            3'b011:  return 16'hE260;
            3'b100:  return 16'h4521;
            3'b101:  return 16'h3161;
            3'b110:  return 16'h09E0;
            default: return 16'h1DA0;
        endcase
    endfunction

    function automatic logic [31:0] exp_point(input logic [5:0] b, input logic [1:0] m);
        case (m)
            2'd0:    return {16'h0000, b[0] ? 16'hC000 : 16'h4000};
            2'd1:    return {b[1] ? 16'hD2BF : 16'h2D41, b[0] ? 16'hD2BF : 16'h2D41};
            2'd2:    return {ref16(b[3:2]), ref16(b[1:0])};
            default: return {ref64(b[5:3]), ref64(b[2:0])};
        endcase
    endfunction

    // One clock: drive at the falling edge, sample 1 ns later, pop/push the
    // scoreboard for the handshakes that will occur at the next rising edge.
    task automatic cycle(input logic cyc, input logic stb, input logic [5:0] d,
                         input logic [1:0] m, input logic ack_in,
                         input logic [31:0] exp_in, output obs_t o);
        CYC_I = cyc; STB_I = stb; WE_I = stb; DAT_I = d; MOD_I = m; ACK_I = ack_in;
        #1;
        o.ack = ACK_O; o.stb = STB_O; o.we = WE_O; o.cyc = CYC_O; o.dat = DAT_O;
        o.hs = STB_O & ack_in;
        o.sb_empty = 1'b0;
        o.exp = '0;
        if (o.hs) begin
            if (sb.size() == 0) o.sb_empty = 1'b1;
            else o.exp = sb.pop_front();
        end
        if (o.ack) sb.push_back(exp_in);
        @(negedge CLK_I);
    endtask

    task automatic test_reset();
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b0;
        DAT_I = '0; MOD_I = '0;
        #2;
        checks++; if (STB_O !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b want=0", STB_O); end
        checks++; if (WE_O !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", WE_O); end
        checks++; if (DAT_O !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h want=0", DAT_O); end
        checks++; if (CYC_O !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%b want=0", CYC_O); end
        checks++; if (ACK_O !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ACK_O); end
        @(negedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b0;
    endtask

    task automatic test_qpsk_back_to_back();
        logic [31:0] lit [4] = '{32'h2D412D41, 32'h2D41D2BF, 32'hD2BF2D41, 32'hD2BFD2BF};
        obs_t o;
        int first_ack = -1, first_stb = -1, last_stb = -1, n_hs = 0, we_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, i < 4, 6'(i), 2'd1, 1'b1, lit[i % 4], o);
            if (o.ack && first_ack < 0) first_ack = i;
            if (o.stb) begin
                if (first_stb < 0) first_stb = i;
                last_stb = i;
            end
            if (o.we !== o.stb) we_bad++;
            if (o.hs) begin
                n_hs++;
                checks++;
                if (o.sb_empty || o.dat !== o.exp) begin
                    failures++;
                    $display("FAIL qpsk_data got=%h want=%h extra=%b", o.dat, o.exp, o.sb_empty);
                end
            end
        end
        checks++; if (n_hs != 4) begin failures++; $display("FAIL qpsk_count got=%0d want=4", n_hs); end
        checks++; if (first_stb != first_ack + 2) begin
            failures++; $display("FAIL qpsk_latency got=%0d want=%0d", first_stb, first_ack + 2);
        end
        checks++; if (last_stb - first_stb != 3) begin
            failures++; $display("FAIL qpsk_rate got=%0d want=3", last_stb - first_stb);
        end
        checks++; if (we_bad != 0) begin failures++; $display("FAIL we_follows_stb got=%0d want=0", we_bad); end
    endtask

    task automatic test_constants();
        logic [5:0]  d [5] = '{6'b100_010, 6'b000_001, 6'b000_000, 6'b00_1001, 6'b111_000};
        logic [1:0]  m [5] = '{2'd3, 2'd0, 2'd0, 2'd2, 2'd3};
        logic [31:0] e [5] = '{32'h4521F620, 32'h0000C000, 32'h00004000, 32'h3CB7EBC3, 32'h1DA0BADF};
        obs_t o;
        int n_hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) cycle(1'b1, 1'b1, d[i], m[i], 1'b1, e[i], o);
            else       cycle(1'b1, 1'b0, 6'd0, 2'd0, 1'b1, 32'h0, o);
            if (o.hs) begin
                n_hs++;
                checks++;
                if (o.sb_empty || o.dat !== o.exp) begin
                    failures++;
                    $display("FAIL const_data got=%h want=%h extra=%b", o.dat, o.exp, o.sb_empty);
                end
            end
        end
        checks++; if (n_hs != 5) begin failures++; $display("FAIL const_count got=%0d want=5", n_hs); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [5:0] d;
        logic [1:0] m;
        int n_ack = 0, n_hs = 0;
        for (int i = 0; i < 10; i++) begin
            d = 6'($urandom);
            m = 2'($urandom);
            cycle(1'b1, 1'b1, d, m, 1'b0, exp_point(d, m), o);
            if (o.ack) n_ack++;
        end
        checks++; if (n_ack != DEPTH) begin failures++; $display("FAIL bp_acks got=%0d want=%0d", n_ack, DEPTH); end
        checks++; if (o.ack !== 1'b0) begin failures++; $display("FAIL bp_ack_low got=%b want=0", o.ack); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 6'd0, 2'd0, 1'b1, 32'h0, o);
            if (o.hs) begin
                n_hs++;
                checks++;
                if (o.sb_empty || o.dat !== o.exp) begin
                    failures++;
                    $display("FAIL bp_data got=%h want=%h extra=%b", o.dat, o.exp, o.sb_empty);
                end
            end
        end
        checks++; if (n_hs != DEPTH) begin failures++; $display("FAIL bp_drain got=%0d want=%0d", n_hs, DEPTH); end
    endtask

    task automatic test_mode_interleave();
        obs_t o;
        logic [5:0] d = 6'($urandom);
        logic [1:0] m;
        int sent = 0, got = 0, cyc_n = 0;
        while ((sent < 16 || got < 16) && cyc_n < 300) begin
            cyc_n++;
            if (sent < 16) begin
                m = sent[0] ? 2'd3 : 2'd2;
                cycle(1'b1, 1'b1, d, m, 1'($urandom_range(0, 1)), exp_point(d, m), o);
                if (o.ack) begin
                    sent++;
                    d = 6'($urandom);
                end
            end else begin
                cycle(1'b1, 1'b0, 6'd0, 2'd0, 1'b1, 32'h0, o);
            end
            if (o.hs) begin
                got++;
                checks++;
                if (o.sb_empty || o.dat !== o.exp) begin
                    failures++;
                    $display("FAIL mix_data got=%h want=%h extra=%b", o.dat, o.exp, o.sb_empty);
                end
            end
        end
        checks++; if (sent != 16 || got != 16) begin
            failures++; $display("FAIL mix_count sent=%0d got=%0d want=16", sent, got);
        end
    endtask

    task automatic test_end_of_frame();
        obs_t o;
        logic cyc_hist [6];
        int n_ack = 0, n_hs = 0, last_hs = -1, cyc_low = 0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 6'(i + 5), 2'd2, 1'b0, exp_point(6'(i + 5), 2'd2), o);
            if (o.ack) n_ack++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 6'd0, 2'd0, 1'b0, 32'h0, o);
            if (o.cyc !== 1'b1) cyc_low++;
        end
        checks++; if (n_ack != 2 || cyc_low != 0) begin
            failures++; $display("FAIL eof_hold acks=%0d cyc_low=%0d want 2/0", n_ack, cyc_low);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 6'd0, 2'd0, 1'b1, 32'h0, o);
            cyc_hist[i] = o.cyc;
            if (o.hs) begin
                n_hs++;
                last_hs = i;
                checks++;
                if (o.sb_empty || o.dat !== o.exp) begin
                    failures++;
                    $display("FAIL eof_data got=%h want=%h extra=%b", o.dat, o.exp, o.sb_empty);
                end
            end
        end
        checks++;
        if (n_hs != 2 || last_hs < 0 || last_hs > 3) begin
            failures++; $display("FAIL eof_drain got=%0d last=%0d want=2", n_hs, last_hs);
        end else if (cyc_hist[last_hs + 1] !== 1'b1 || cyc_hist[last_hs + 2] !== 1'b0) begin
            failures++;
            $display("FAIL eof_cyc got=%b%b want=10", cyc_hist[last_hs + 1], cyc_hist[last_hs + 2]);
        end
    endtask

    task automatic test_reset_midstream();
        obs_t o;
        int n_hs = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 6'(i + 9), 2'd3, 1'b0, exp_point(6'(i + 9), 2'd3), o);
        end
        cycle(1'b1, 1'b0, 6'd0, 2'd0, 1'b0, 32'h0, o);
        checks++; if (STB_O !== 1'b1) begin failures++; $display("FAIL mid_pre_stb got=%b want=1", STB_O); end
        #2;
        RST_I = 1'b1;
        #1;
        checks++; if (STB_O !== 1'b0) begin failures++; $display("FAIL mid_rst_stb got=%b want=0", STB_O); end
        checks++; if (DAT_O !== 32'h0) begin failures++; $display("FAIL mid_rst_dat got=%h want=0", DAT_O); end
        checks++; if (CYC_O !== 1'b0) begin failures++; $display("FAIL mid_rst_cyc got=%b want=0", CYC_O); end
        checks++; if (ACK_O !== 1'b0) begin failures++; $display("FAIL mid_rst_ack got=%b want=0", ACK_O); end
        sb.delete();
        @(negedge CLK_I);
        RST_I = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) cycle(1'b1, 1'b1, 6'h2A, 2'd2, 1'b1, exp_point(6'h2A, 2'd2), o);
            else        cycle(1'b1, 1'b0, 6'd0, 2'd0, 1'b1, 32'h0, o);
            if (o.hs) begin
                n_hs++;
                checks++;
                if (o.sb_empty || o.dat !== o.exp) begin
                    failures++;
                    $display("FAIL mid_after_data got=%h want=%h extra=%b", o.dat, o.exp, o.sb_empty);
                end
            end
        end
        checks++; if (n_hs != 1) begin failures++; $display("FAIL mid_after_count got=%0d want=1", n_hs); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_qpsk_back_to_back();
        test_constants();
        test_backpressure();
        test_mode_interleave();
        test_end_of_frame();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
